// File: rtl/muxn_reg_if.sv
// Handshake bundle for muxn_reg: upstream select/data beat in, registered
// selected beat out, plus the sticky out-of-range select flag.
interface muxn_reg_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = ($clog2(NUM_IN) < 1) ? 1 : $clog2(NUM_IN);

  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] d;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        y;
  logic [SEL_W-1:0]        y_sel;
  logic                    sel_err;

  modport master (
    output in_valid, sel, d, out_ready,
    input  in_ready, out_valid, y, y_sel, sel_err
  );

  modport slave (
    input  in_valid, sel, d, out_ready,
    output in_ready, out_valid, y, y_sel, sel_err
  );
endinterface

// File: rtl/muxn_reg.sv
// N-way registered mux behind a 2-entry skid buffer; the selected word and its
// select index travel together as one beat.
//   state | meaning
//   EMPTY | no beat held, head stale
//   ONE   | head holds the oldest beat
//   TWO   | head and tail both hold beats, upstream stalled
module muxn_reg #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
) (
  input  logic     clk,
  input  logic     reset,
  muxn_reg_if.slave bus
);
  localparam int SEL_W = ($clog2(NUM_IN) < 1) ? 1 : $clog2(NUM_IN);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             sel_err_q;
  logic [WIDTH-1:0] head_y;
  logic [SEL_W-1:0] head_sel;
  logic [WIDTH-1:0] tail_y;
  logic [SEL_W-1:0] tail_sel;

  logic [WIDTH-1:0] cap_y;
  logic             cap_ok;
  logic             push;
  logic             pop;

  // Loop compare keeps the part-select in range even when sel exceeds NUM_IN-1.
  always_comb begin
    cap_y  = '0;
    cap_ok = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        cap_y  = bus.d[k*WIDTH +: WIDTH];
        cap_ok = 1'b1;
      end
    end
  end

  assign push = bus.in_valid && in_ready_q;
  assign pop  = out_valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      head_y      <= '0;
      head_sel    <= '0;
      tail_y      <= '0;
      tail_sel    <= '0;
    end else begin
      if (push && !cap_ok) begin
        sel_err_q <= 1'b1;
      end

      case (state)
        EMPTY: begin
          in_ready_q <= 1'b1;
          if (push) begin
            head_y      <= cap_y;
            head_sel    <= bus.sel;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end

        ONE: begin
          if (push && pop) begin
            head_y     <= cap_y;
            head_sel   <= bus.sel;
            in_ready_q <= 1'b1;
          end else if (push) begin
            tail_y     <= cap_y;
            tail_sel   <= bus.sel;
            in_ready_q <= 1'b0;
            state      <= TWO;
          end else if (pop) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= EMPTY;
          end
        end

        TWO: begin
          // in_ready is low here, so only a pop can move the buffer.
          if (pop) begin
            head_y     <= tail_y;
            head_sel   <= tail_sel;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = head_y;
  assign bus.y_sel     = head_sel;
  assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_muxn_reg.sv
// Scoreboard bench for muxn_reg: a 4-input instance carries the main traffic,
// a 5-input instance covers out-of-range selects.
module tb_muxn_reg;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit rand_rdy = 1'b0;

  logic [34:0] q4[$];
  logic [34:0] q5[$];

  muxn_reg_if #(.WIDTH(32), .NUM_IN(4)) bus4 ();
  muxn_reg_if #(.WIDTH(32), .NUM_IN(5)) bus5 ();

  muxn_reg #(.WIDTH(32), .NUM_IN(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
  muxn_reg #(.WIDTH(32), .NUM_IN(5)) u_dut5 (.clk(clk), .reset(reset), .bus(bus5));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus4.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send4(input logic [1:0] s, input logic [127:0] dv, input logic [31:0] ey);
    bit acc;
    acc = 1'b0;
    bus4.sel      = s;
    bus4.d        = dv;
    bus4.in_valid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      if (bus4.in_ready) begin
        q4.push_back({1'b0, s, ey});
        acc = 1'b1;
      end
      tick();
    end
    bus4.in_valid = 1'b0;
    bus4.d        = {4{$urandom()}};
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send4_timeout actual=not_accepted required=accepted sel=%0d", s);
    end
  endtask

  task automatic send5(input logic [2:0] s, input logic [31:0] ey);
    bit acc;
    acc = 1'b0;
    bus5.sel      = s;
    bus5.in_valid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      if (bus5.in_ready) begin
        q5.push_back({s, ey});
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus5.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send5_timeout actual=not_accepted required=accepted sel=%0d", s);
    end
  endtask

  initial begin : mon4
    logic        prev_stall;
    logic [31:0] prev_y;
    logic [1:0]  prev_sel;
    logic [34:0] e;
    prev_stall = 1'b0;
    prev_y     = '0;
    prev_sel   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && bus4.out_valid) begin
          chk("stall_y", bus4.y, prev_y);
          chk("stall_ysel", bus4.y_sel, prev_sel);
        end
        if (bus4.out_valid && bus4.out_ready) begin
          if (q4.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop4_unexpected actual_y=%0h required=no_beat", bus4.y);
          end else begin
            e = q4.pop_front();
            chk("pop4_y", bus4.y, e[31:0]);
            chk("pop4_ysel", bus4.y_sel, e[33:32]);
          end
        end
        prev_stall = bus4.out_valid && !bus4.out_ready;
        prev_y     = bus4.y;
        prev_sel   = bus4.y_sel;
      end
    end
  end

  initial begin : mon5
    logic [34:0] e;
    forever begin
      @(negedge clk);
      if (!reset && bus5.out_valid && bus5.out_ready) begin
        if (q5.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop5_unexpected actual_y=%0h required=no_beat", bus5.y);
        end else begin
          e = q5.pop_front();
          chk("pop5_y", bus5.y, e[31:0]);
          chk("pop5_ysel", bus5.y_sel, e[34:32]);
        end
      end
    end
  end

  initial begin : drive
    logic [127:0] d4f;
    logic [127:0] dv;
    logic [31:0]  w[4];
    logic [1:0]   s;
    int           c0;

    reset          = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.sel       = '0;
    bus4.d         = '0;
    bus4.out_ready = 1'b0;
    bus5.in_valid  = 1'b0;
    bus5.sel       = '0;
    bus5.d         = '0;
    bus5.out_ready = 1'b0;
    d4f = {32'h33, 32'h22, 32'h11, 32'h00};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus4.out_valid, 0);
    chk("rst_y", bus4.y, 0);
    chk("rst_ysel", bus4.y_sel, 0);
    chk("rst_in_ready", bus4.in_ready, 0);
    chk("rst_sel_err", bus5.sel_err, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_in_ready", bus4.in_ready, 1);

    // single beat, one-cycle latency, then empty
    bus4.out_ready = 1'b1;
    send4(2'd2, d4f, 32'h22);
    chk("lat_out_valid", bus4.out_valid, 1);
    chk("lat_y", bus4.y, 32'h22);
    chk("lat_ysel", bus4.y_sel, 2);
    tick();
    chk("lat_empty", bus4.out_valid, 0);

    // fill to TWO with downstream stalled
    bus4.out_ready = 1'b0;
    send4(2'd0, d4f, 32'h00);
    chk("one_in_ready", bus4.in_ready, 1);
    send4(2'd1, d4f, 32'h11);
    chk("two_in_ready", bus4.in_ready, 0);
    chk("two_head_y", bus4.y, 32'h00);
    chk("two_out_valid", bus4.out_valid, 1);
    bus4.sel      = 2'd3;
    bus4.d        = d4f;
    bus4.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("two_block", bus4.in_ready, 0);
      tick();
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    repeat (3) tick();
    chk("two_drained", bus4.out_valid, 0);
    chk("two_q_empty", q4.size(), 0);

    // out-of-range select on the 5-input instance
    bus5.d         = {32'h44, 32'h33, 32'h22, 32'h11, 32'h00};
    bus5.out_ready = 1'b1;
    send5(3'd1, 32'h11);
    chk("err_clear", bus5.sel_err, 0);
    send5(3'd6, 32'h0);
    chk("err_set", bus5.sel_err, 1);
    chk("err_y", bus5.y, 0);
    chk("err_ysel", bus5.y_sel, 6);
    send5(3'd4, 32'h44);
    chk("err_sticky", bus5.sel_err, 1);
    chk("err_y4", bus5.y, 32'h44);

    // reset while holding two beats
    bus4.out_ready = 1'b0;
    send4(2'd0, d4f, 32'h00);
    send4(2'd3, d4f, 32'h33);
    chk("pre_rst_two", bus4.in_ready, 0);
    reset          = 1'b1;
    bus4.in_valid  = 1'b1;
    bus4.sel       = 2'd2;
    bus4.out_ready = 1'b1;
    q4.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", bus4.out_valid, 0);
    chk("mid_rst_y", bus4.y, 0);
    chk("mid_rst_ysel", bus4.y_sel, 0);
    chk("mid_rst_in_ready", bus4.in_ready, 0);
    chk("mid_rst_sel_err", bus5.sel_err, 0);
    reset         = 1'b0;
    bus4.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", bus4.in_ready, 1);
    chk("post_rst_out_valid", bus4.out_valid, 0);
    repeat (2) tick();

    // full-rate streaming
    bus4.out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      for (int k = 0; k < 4; k++) dv[k*32 +: 32] = {16'(i), 16'(k)};
      send4(2'(i), dv, {16'(i), 16'(i % 4)});
    end
    chk("stream_cycles", 64'(cyc - c0), 100);

    // random stalls on both sides
    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      while ($urandom_range(0, 1) == 0) tick();
      for (int k = 0; k < 4; k++) begin
        w[k] = $urandom();
        dv[k*32 +: 32] = w[k];
      end
      s = 2'($urandom_range(0, 3));
      send4(s, dv, w[s]);
    end
    rand_rdy       = 1'b0;
    bus4.out_ready = 1'b1;
    for (int n = 0; n < 100 && q4.size() != 0; n++) tick();
    chk("final_q4_empty", q4.size(), 0);
    chk("final_q5_empty", q5.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muxn_reg.md
MUXN_REG -- requirements
Module: muxn_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each input and of the output.
REQ-002 SHALL have parameter NUM_IN, default 4, number of data inputs, legal range 2..16 (need not be a power of 2).
REQ-003 SHALL have derived localparam SEL_W = clog2(NUM_IN), minimum 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream presents sel and d this cycle.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 sel  input  SEL_W  input index to select.
REQ-009 d  input  NUM_IN*WIDTH  flattened data inputs; input k at bits [k*WIDTH +: WIDTH].
REQ-010 out_valid  output  1  y/y_sel hold a valid beat.
REQ-011 out_ready  input  1  downstream consumes the beat this cycle.
REQ-012 y  output  WIDTH  selected data, registered.
REQ-013 y_sel  output  SEL_W  sel value captured with the beat in y.
REQ-014 sel_err  output  1  sticky flag: an out-of-range sel was accepted.

Function
REQ-015 Accept ("push") SHALL occur when in_valid && in_ready on a rising edge; consume ("pop") when out_valid && out_ready.
REQ-016 Captured data SHALL be d[sel*WIDTH +: WIDTH] when sel < NUM_IN; otherwise all-zero, with sel_err set.
REQ-017 Selection SHALL be sampled only at the push edge; later changes to sel/d SHALL NOT affect stored beats.
REQ-018 Storage SHALL be a 2-entry skid buffer (head = output register, tail = skid register); FSM states EMPTY, ONE, TWO.
REQ-019 EMPTY: push -> ONE, beat into head; no push -> EMPTY.
REQ-020 ONE: push only -> TWO, beat into tail; pop only -> EMPTY; push+pop -> ONE, new beat into head; neither -> ONE, head held.
REQ-021 TWO: pop -> ONE, tail moves into head; no pop -> TWO, both held; push impossible (in_ready=0).
REQ-022 in_ready SHALL be a registered output: 1 iff the next state is EMPTY or ONE, so it is never combinationally dependent on out_ready or in_valid.
REQ-023 out_valid SHALL be 1 iff state is ONE or TWO; y and y_sel SHALL always show the head entry.
REQ-024 Latency SHALL be 1 cycle: a beat pushed at edge N appears on y at edge N when the buffer was EMPTY or popped simultaneously.
REQ-025 Beats SHALL leave in push order; no beat SHALL be dropped or duplicated.
REQ-026 With out_ready held 1 and in_valid held 1, throughput SHALL be one beat per cycle.
REQ-027 While out_valid=1 and out_ready=0, y and y_sel SHALL be stable.
REQ-028 sel_err SHALL set on the push edge of an out-of-range sel and stay 1 until reset; in-range pushes SHALL NOT clear it.
REQ-029 A payload with out-of-range sel SHALL still flow as a normal beat (y=0, y_sel=raw sel).

Reset
REQ-030 While reset=1 at a rising edge: state=EMPTY, out_valid=0, y=0, y_sel=0, sel_err=0, in_ready=0.
REQ-031 in_ready SHALL go to 1 on the first rising edge with reset=0.
REQ-032 Reset mid-operation SHALL discard both buffered beats with no output; in_valid/out_ready SHALL be ignored while reset=1.

Verification
REQ-033 NUM_IN=4, WIDTH=32, d={0x33,0x22,0x11,0x00}, out_ready=1, push sel=2 -> next cycle y=0x22, y_sel=2, out_valid=1; one cycle later out_valid=0.
REQ-034 out_ready=0, push sel=0,1,3 on consecutive cycles -> in_ready=0 after the 2nd push, 3rd beat not accepted; raise out_ready -> y=0x00 then 0x11, then EMPTY.
REQ-035 NUM_IN=5 (SEL_W=3), push sel=6 -> y=0, y_sel=6, sel_err=1; then push sel=4 -> y=d4, sel_err remains 1.
REQ-036 Streaming 100 beats, in_valid=1, out_ready=1 -> 100 outputs in order, one per cycle, none lost.
REQ-037 State TWO, assert reset 1 cycle -> out_valid=0, y=0, sel_err=0, in_ready=0 during reset and 1 the next cycle; no stale beat ever appears.
REQ-038 Random in_valid/out_ready stalls (~50 % each), 10k beats vs scoreboard -> zero mismatches, y stable whenever stalled.
